// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one fixed-latency add/subtract core among N_REQ requesters.
// Results return through a credit-protected FIFO in acceptance order, tagged with the requester id.
module addsub_arbiter #(
   parameter int N_REQ      = 4,
   parameter int WIDTH      = 89,
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 8,
   localparam int IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ-1:0]       req_sub,
   output logic [WIDTH-1:0]       add_a,
   output logic [WIDTH-1:0]       add_b,
   output logic                   add_sub,
   input  logic [WIDTH-1:0]       add_s,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [WIDTH-1:0]       rsp_data
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [IDW-1:0]           rr_ptr_r;
   logic [CW-1:0]            credit_r;
   logic                     credit_ok_s;
   logic                     grant_s;
   logic [IDW-1:0]           gidx_s;
   logic [WIDTH-1:0]         sel_a_s;
   logic [WIDTH-1:0]         sel_b_s;
   logic                     sel_sub_s;
   logic [WIDTH-1:0]         add_a_r;
   logic [WIDTH-1:0]         add_b_r;
   logic                     add_sub_r;
   logic [LAT-1:0]           vld_sr_r;
   logic [LAT-1:0][IDW-1:0]  id_sr_r;
   logic [WIDTH-1:0]         mem_r   [FIFO_DEPTH];
   logic [IDW-1:0]           memid_r [FIFO_DEPTH];
   logic [PW-1:0]            wr_ptr_r;
   logic [PW-1:0]            rd_ptr_r;
   logic [CW-1:0]            count_r;
   logic                     push_s;
   logic                     pop_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(FIFO_DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + 1'b1;
      end
   endfunction

   // Credit counts both in-flight ops and queued results, so a grant can never overflow the FIFO.
   assign credit_ok_s = (credit_r < CW'(FIFO_DEPTH));

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      logic [IDW-1:0] cand;
      grant_s = 1'b0;
      gidx_s  = {IDW{1'b0}};
      cand    = rr_ptr_r;
      for (int k = 0; k < N_REQ; k++) begin
         if (cand == IDW'(N_REQ - 1)) begin
            cand = {IDW{1'b0}};
         end else begin
            cand = cand + 1'b1;
         end
         if (!grant_s && req_valid[cand] && credit_ok_s && !rst) begin
            grant_s = 1'b1;
            gidx_s  = cand;
         end else begin
            grant_s = grant_s;
         end
      end
   end

   // One-hot ready plus same-cycle operand forwarding to the core.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = grant_s && (gidx_s == IDW'(i));
      end
      sel_a_s   = req_a[gidx_s*WIDTH +: WIDTH];
      sel_b_s   = req_b[gidx_s*WIDTH +: WIDTH];
      sel_sub_s = req_sub[gidx_s];
      if (grant_s) begin
         add_a   = sel_a_s;
         add_b   = sel_b_s;
         add_sub = sel_sub_s;
      end else begin
         add_a   = add_a_r;
         add_b   = add_b_r;
         add_sub = add_sub_r;
      end
   end

   // Arbitration pointer, operand hold registers and credit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r  <= IDW'(N_REQ - 1);
         add_a_r   <= {WIDTH{1'b0}};
         add_b_r   <= {WIDTH{1'b0}};
         add_sub_r <= 1'b0;
         credit_r  <= {CW{1'b0}};
      end else begin
         if (grant_s) begin
            rr_ptr_r  <= gidx_s;
            add_a_r   <= sel_a_s;
            add_b_r   <= sel_b_s;
            add_sub_r <= sel_sub_s;
         end
         case ({grant_s, pop_s})
            2'b10:   credit_r <= credit_r + 1'b1;
            2'b01:   credit_r <= credit_r - 1'b1;
            default: credit_r <= credit_r;
         endcase
      end
   end

   // Valid/id tag pipeline aligned with the core's LAT-cycle latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_sr_r <= {LAT{1'b0}};
         id_sr_r  <= {(LAT*IDW){1'b0}};
      end else begin
         vld_sr_r[0] <= grant_s;
         id_sr_r[0]  <= gidx_s;
         for (int k = 1; k < LAT; k++) begin
            vld_sr_r[k] <= vld_sr_r[k-1];
            id_sr_r[k]  <= id_sr_r[k-1];
         end
      end
   end

   assign push_s    = vld_sr_r[LAT-1];
   assign rsp_valid = (count_r != {CW{1'b0}});
   assign pop_s     = rsp_valid && rsp_ready;
   assign rsp_data  = mem_r[rd_ptr_r];
   assign rsp_id    = memid_r[rd_ptr_r];

   // Result FIFO; storage is cleared so the head reads zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i]   <= {WIDTH{1'b0}};
            memid_r[i] <= {IDW{1'b0}};
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r]   <= add_s;
            memid_r[wr_ptr_r] <= id_sr_r[LAT-1];
            wr_ptr_r          <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomized bench for addsub_arbiter: behavioural core model plus a queue-based scoreboard
// tracking grants, credit, result timing and ordering.
module tb_addsub_arbiter;

   localparam int N   = 4;
   localparam int W   = 89;
   localparam int LAT = 3;
   localparam int D   = 8;
   localparam int IDW = 2;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic [N-1:0]     req_sub;
   logic [W-1:0]     add_a;
   logic [W-1:0]     add_b;
   logic             add_sub;
   logic [W-1:0]     add_s;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [IDW-1:0]   rsp_id;
   logic [W-1:0]     rsp_data;

   addsub_arbiter #(.N_REQ(N), .WIDTH(W), .LAT(LAT), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
      .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_s(add_s),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // c_addsub core stand-in: LAT register stages, no reset.
   logic [W-1:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= add_sub ? (add_a - add_b) : (add_a + add_b);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign add_s = pipe[LAT-1];

   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0]   data;
      int             avail;
   } exp_t;

   exp_t         q[$];
   int           outstanding;
   int           last_g;
   logic [W-1:0] last_a;
   logic [W-1:0] last_b;
   logic         last_sub;
   int           cyc;
   int           dut_acc;
   int           dut_pop;
   int           total;
   int           bad;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard: credit = accepted minus popped; results become visible LAT+1 cycles after acceptance.
   always @(negedge clk) begin : mon
      int           g;
      int           c;
      logic [N-1:0] exp_rdy;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] d;
      logic         ev;
      cyc++;
      if (rst) begin
         chk("rst_ready", 128'(req_ready), 128'(0));
         chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
         chk("rst_rsp_id", 128'(rsp_id), 128'(0));
         chk("rst_rsp_data", 128'(rsp_data), 128'(0));
         chk("rst_add", 128'({add_sub, add_a, add_b}), 128'(0));
         q.delete();
         outstanding = 0;
         last_g      = N - 1;
         last_a      = '0;
         last_b      = '0;
         last_sub    = 1'b0;
         dut_acc     = 0;
         dut_pop     = 0;
      end else begin
         g       = -1;
         exp_rdy = '0;
         if (outstanding < D) begin
            for (int k = 1; k <= N; k++) begin
               c = (last_g + k) % N;
               if (g < 0 && req_valid[c[IDW-1:0]]) g = c;
            end
         end
         if (g >= 0) exp_rdy[g[IDW-1:0]] = 1'b1;
         chk("grant", 128'(req_ready), 128'(exp_rdy));
         if (|(req_valid & req_ready)) dut_acc++;
         if (g >= 0) begin
            a        = req_a[g*W +: W];
            b        = req_b[g*W +: W];
            d        = req_sub[g[IDW-1:0]] ? (a - b) : (a + b);
            last_a   = a;
            last_b   = b;
            last_sub = req_sub[g[IDW-1:0]];
            last_g   = g;
            outstanding++;
            q.push_back('{id: g[IDW-1:0], data: d, avail: cyc + LAT + 1});
         end
         chk("add_ops", 128'({add_sub, add_a}), 128'({last_sub, last_a}));
         chk("add_b", 128'(add_b), 128'(last_b));
         ev = (q.size() > 0) && (q[0].avail <= cyc);
         chk("rsp_valid", 128'(rsp_valid), 128'(ev));
         if (rsp_valid && rsp_ready) dut_pop++;
         if (ev) begin
            chk("rsp_id", 128'(rsp_id), 128'(q[0].id));
            chk("rsp_data", 128'(rsp_data), 128'(q[0].data));
            if (rsp_ready) begin
               void'(q.pop_front());
               outstanding--;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rnd();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_sub[i]      = s;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) set_op(i, rnd(), rnd(), 1'($urandom_range(0, 1)));
   endtask

   initial begin
      logic [W-1:0] ones;
      int           a0;
      ones      = '1;
      total     = 0;
      bad       = 0;
      cyc       = 0;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      rsp_ready = 1'b1;
      repeat (3) step();

      // single add from requester 2, granted in the first cycle after reset
      rst = 1'b0;
      set_op(2, 89'd5, 89'd3, 1'b0);
      req_valid = 4'b0100;
      step();
      req_valid = 4'b0000;
      repeat (2) step();
      chk("lat_early", 128'(rsp_valid), 128'(0));
      step();
      chk("lat_valid", 128'(rsp_valid), 128'(1));
      chk("lat_id", 128'(rsp_id), 128'(2));
      chk("lat_data", 128'(rsp_data), 128'(8));

      // subtract wrap-around
      set_op(0, 89'd0, 89'd1, 1'b1);
      req_valid = 4'b0001;
      step();
      req_valid = 4'b0000;
      repeat (3) step();
      chk("wrap_data", 128'(rsp_data), 128'(ones));
      repeat (4) step();

      // all requesters valid continuously from reset
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      req_valid = 4'b1111;
      repeat (24) begin
         rand_ops();
         step();
      end
      req_valid = 4'b0000;
      repeat (6) step();

      // backpressure fills credit, then release
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      a0 = dut_acc;
      repeat (15) begin
         rand_ops();
         step();
      end
      chk("bp_accepts", 128'(dut_acc - a0), 128'(8));
      chk("bp_ready", 128'(req_ready), 128'(0));
      rsp_ready = 1'b1;
      repeat (20) begin
         rand_ops();
         step();
      end
      req_valid = 4'b0000;
      repeat (12) step();
      chk("bp_no_loss", 128'(dut_pop), 128'(dut_acc));

      // random traffic with random backpressure
      repeat (300) begin
         req_valid = 4'($urandom_range(0, 15));
         rand_ops();
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      repeat (14) step();

      // reset with three ops in flight and two queued
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      repeat (5) begin
         rand_ops();
         step();
      end
      req_valid = 4'b0000;
      rst = 1'b1;
      #1;
      chk("rst_imm_valid", 128'(rsp_valid), 128'(0));
      repeat (2) step();
      rst = 1'b0;
      rsp_ready = 1'b1;
      repeat (8) step();
      set_op(1, rnd(), rnd(), 1'b1);
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0000;
      repeat (6) step();

      // sparse alternating requests with idle gaps
      repeat (6) begin
         set_op(1, rnd(), rnd(), 1'($urandom_range(0, 1)));
         set_op(3, rnd(), rnd(), 1'($urandom_range(0, 1)));
         req_valid = 4'b0010;
         step();
         req_valid = 4'b0000;
         step();
         req_valid = 4'b1000;
         step();
         req_valid = 4'b0000;
         repeat (2) step();
      end
      repeat (8) step();
      chk("final_no_loss", 128'(dut_pop), 128'(dut_acc));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
